// File: rtl/icache.sv
// Direct-mapped, blocking instruction cache with a line-refill port.
// Ports: clk/rst, im_req_* fetch in, im_resp_* word out,
//   inv_req fence.i pulse, bm_req_* refill request, bm_resp_* refill beats.
module icache #(
  parameter int SETS       = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] im_req_addr,
  input  logic        im_req_valid,
  output logic        im_req_ready,
  output logic [63:0] im_resp_rdata,
  output logic        im_resp_valid,
  input  logic        inv_req,
  output logic [63:0] bm_req_addr,
  output logic        bm_req_valid,
  input  logic        bm_req_ready,
  input  logic [63:0] bm_resp_rdata,
  input  logic        bm_resp_valid
);

  localparam int OFF_W  = $clog2(LINE_BEATS * 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WOFF_W = $clog2(LINE_BEATS);
  localparam int LINE_W = 64 - OFF_W;
  localparam int TAG_W  = 64 - OFF_W - IDX_W;

  localparam logic [2:0] INIT      = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] LOOKUP    = 3'd2;
  localparam logic [2:0] MISS_REQ  = 3'd3;
  localparam logic [2:0] MISS_WAIT = 3'd4;
  localparam logic [2:0] RESP      = 3'd5;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SETS - 1);
  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(LINE_BEATS - 1);

  logic [2:0]        state;
  logic [IDX_W-1:0]  sweep_idx;
  logic              inv_pend;
  logic [WOFF_W-1:0] beat_cnt;

  logic [LINE_W-1:0] line_q;
  logic [WOFF_W-1:0] woff_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;

  logic [SETS-1:0]   valid_bits;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [63:0]       data_mem [SETS*LINE_BEATS];

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [63:0]       rd_data;
  logic [63:0]       resp_word;

  logic [IDX_W-1:0]  req_idx;
  logic [WOFF_W-1:0] req_woff;
  logic [LINE_W-1:0] req_line;

  logic hit;
  logic inv_any;
  logic accept;
  logic sweep_we;
  logic beat_we;
  logic fill_done;
  logic unused_bits;

  assign unused_bits = ^im_req_addr[2:0];

  assign req_line = im_req_addr[63:OFF_W];
  assign req_idx  = im_req_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_woff = im_req_addr[OFF_W-1:3];

  assign idx_q = line_q[IDX_W-1:0];
  assign tag_q = line_q[LINE_W-1:IDX_W];

  always_comb begin
    hit       = (state == LOOKUP) && rd_valid
                && (rd_tag == tag_q);
    inv_any   = inv_req || inv_pend;
    // A pending or arriving invalidate blocks new
    // fetches so the sweep starts as soon as possible.
    im_req_ready = !rst && !inv_any
                   && ((state == IDLE) || hit);
    accept    = im_req_ready && im_req_valid;
    im_resp_valid = !rst
                    && (hit || (state == RESP));
    im_resp_rdata = 64'd0;
    if (!rst && hit)
      im_resp_rdata = rd_data;
    else if (!rst && (state == RESP))
      im_resp_rdata = resp_word;
    bm_req_valid = !rst && (state == MISS_REQ);
    bm_req_addr  = {line_q, {OFF_W{1'b0}}};
    sweep_we  = !rst && (state == INIT);
    beat_we   = !rst && (state == MISS_WAIT)
                && bm_resp_valid;
    fill_done = beat_we && (beat_cnt == LAST_BEAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      sweep_idx <= '0;
      inv_pend  <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      if (inv_req)
        inv_pend <= 1'b1;
      unique case (state)
        INIT: begin
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_idx == LAST_IDX)
            state <= IDLE;
        end
        IDLE: begin
          if (inv_any) begin
            state     <= INIT;
            sweep_idx <= '0;
            inv_pend  <= 1'b0;
          end else if (accept) begin
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!hit) begin
            state <= MISS_REQ;
          end else if (accept) begin
            state <= LOOKUP;
          end else if (inv_any) begin
            state     <= INIT;
            sweep_idx <= '0;
            inv_pend  <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        MISS_REQ: begin
          if (bm_req_ready) begin
            state    <= MISS_WAIT;
            beat_cnt <= '0;
          end
        end
        MISS_WAIT: begin
          if (beat_we) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (fill_done)
              state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line_q   <= req_line;
      woff_q   <= req_woff;
      rd_valid <= valid_bits[req_idx];
      rd_tag   <= tag_mem[req_idx];
      rd_data  <= data_mem[{req_idx, req_woff}];
    end
    if (sweep_we)
      valid_bits[sweep_idx] <= 1'b0;
    if (beat_we) begin
      data_mem[{idx_q, beat_cnt}] <= bm_resp_rdata;
      if (beat_cnt == woff_q)
        resp_word <= bm_resp_rdata;
    end
    if (fill_done) begin
      tag_mem[idx_q]    <= tag_q;
      valid_bits[idx_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: reset sweep, miss/hit,
// back-to-back hits, conflict, fence.i, reset mid-refill.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] im_req_addr = '0;
  logic        im_req_valid = 1'b0;
  logic        im_req_ready;
  logic [63:0] im_resp_rdata;
  logic        im_resp_valid;
  logic        inv_req = 1'b0;
  logic [63:0] bm_req_addr;
  logic        bm_req_valid;
  logic        bm_req_ready = 1'b0;
  logic [63:0] bm_resp_rdata = '0;
  logic        bm_resp_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int resp_count = 0;
  int bm_count = 0;

  icache dut (
    .clk          (clk),
    .rst          (rst),
    .im_req_addr  (im_req_addr),
    .im_req_valid (im_req_valid),
    .im_req_ready (im_req_ready),
    .im_resp_rdata(im_resp_rdata),
    .im_resp_valid(im_resp_valid),
    .inv_req      (inv_req),
    .bm_req_addr  (bm_req_addr),
    .bm_req_valid (bm_req_valid),
    .bm_req_ready (bm_req_ready),
    .bm_resp_rdata(bm_resp_rdata),
    .bm_resp_valid(bm_resp_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_resp_valid) resp_count <= resp_count + 1;
    if (bm_req_valid) bm_count <= bm_count + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts at a negedge with the cache idle; ends at the
  // negedge following the RESP cycle.
  task automatic fetch_miss(input logic [63:0] a,
                            input logic [63:0] b0,
                            input logic [63:0] b1,
                            input logic [63:0] b2,
                            input logic [63:0] b3,
                            input logic [63:0] exp,
                            input int inv_beat);
    logic [63:0] bv [4];
    int rc0;
    bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
    rc0 = resp_count;
    chk("idle_ready", {63'd0, im_req_ready}, 64'd1);
    im_req_valid = 1'b1;
    im_req_addr  = a;
    step();
    im_req_valid = 1'b0;
    chk("miss_no_resp", {63'd0, im_resp_valid}, 64'd0);
    chk("miss_ready", {63'd0, im_req_ready}, 64'd0);
    step();
    chk("bm_req_valid", {63'd0, bm_req_valid}, 64'd1);
    chk("bm_req_addr", bm_req_addr, a & ~64'h1f);
    // stray beat while the request is stalled
    bm_resp_valid = 1'b1;
    bm_resp_rdata = 64'hdead_beef_dead_beef;
    step();
    bm_resp_valid = 1'b0;
    chk("bm_req_hold", {63'd0, bm_req_valid}, 64'd1);
    chk("bm_addr_hold", bm_req_addr, a & ~64'h1f);
    bm_req_ready = 1'b1;
    step();
    bm_req_ready = 1'b0;
    chk("bm_req_drop", {63'd0, bm_req_valid}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      bm_resp_valid = 1'b1;
      bm_resp_rdata = bv[i];
      inv_req = (i == inv_beat);
      step();
    end
    bm_resp_valid = 1'b0;
    inv_req = 1'b0;
    chk("resp_valid", {63'd0, im_resp_valid}, 64'd1);
    chk("resp_data", im_resp_rdata, exp);
    chk("resp_ready", {63'd0, im_req_ready}, 64'd0);
    step();
    chk("resp_once", 64'(resp_count), 64'(rc0 + 1));
  endtask

  initial begin
    int cnt;
    int rc;
    int bc;
    @(negedge clk);
    step();
    chk("rst_ready", {63'd0, im_req_ready}, 64'd0);
    chk("rst_rvalid", {63'd0, im_resp_valid}, 64'd0);
    chk("rst_bmvalid", {63'd0, bm_req_valid}, 64'd0);
    chk("rst_rdata", im_resp_rdata, 64'd0);

    rst = 1'b0;
    cnt = 0;
    while (cnt < 200) begin
      step();
      cnt++;
      if (im_req_ready) break;
    end
    chk("sweep_len", 64'(cnt), 64'd64);
    chk("sweep_noresp", 64'(resp_count), 64'd0);

    // cold miss then hit
    fetch_miss(64'h8000_0004, 64'h11, 64'h22,
               64'h33, 64'h44, 64'h11, -1);
    im_req_valid = 1'b1;
    im_req_addr  = 64'h8000_0004;
    step();
    im_req_valid = 1'b0;
    chk("hit_valid", {63'd0, im_resp_valid}, 64'd1);
    chk("hit_data", im_resp_rdata, 64'h11);
    chk("hit_nobm", {63'd0, bm_req_valid}, 64'd0);
    step();
    chk("hit_idle", {63'd0, im_resp_valid}, 64'd0);

    // back-to-back hits
    bc = bm_count;
    rc = resp_count;
    im_req_valid = 1'b1;
    im_req_addr  = 64'h8000_0000;
    step();
    chk("b2b_d0", im_resp_rdata, 64'h11);
    chk("b2b_r0", {63'd0, im_req_ready}, 64'd1);
    im_req_addr = 64'h8000_0008;
    step();
    chk("b2b_d1", im_resp_rdata, 64'h22);
    im_req_addr = 64'h8000_0010;
    step();
    chk("b2b_d2", im_resp_rdata, 64'h33);
    im_req_addr = 64'h8000_0018;
    step();
    chk("b2b_d3", im_resp_rdata, 64'h44);
    chk("b2b_v3", {63'd0, im_resp_valid}, 64'd1);
    im_req_valid = 1'b0;
    step();
    chk("b2b_end", {63'd0, im_resp_valid}, 64'd0);
    chk("b2b_count", 64'(resp_count), 64'(rc + 4));
    chk("b2b_nobm", 64'(bm_count), 64'(bc));

    // conflict on index 0
    fetch_miss(64'h8000_0800, 64'ha1, 64'ha2,
               64'ha3, 64'ha4, 64'ha1, -1);
    fetch_miss(64'h8000_0018, 64'h11, 64'h22,
               64'h33, 64'h44, 64'h44, -1);

    // fence.i during refill
    fetch_miss(64'h8000_0800, 64'ha1, 64'ha2,
               64'ha3, 64'ha4, 64'ha1, -1);
    fetch_miss(64'h8000_0000, 64'h11, 64'h22,
               64'h33, 64'h44, 64'h11, 1);
    cnt = 0;
    while (cnt < 200) begin
      if (im_req_ready) break;
      step();
      cnt++;
    end
    chk("inv_sweep_len", 64'(cnt), 64'd65);
    fetch_miss(64'h8000_0000, 64'h55, 64'h66,
               64'h77, 64'h88, 64'h55, -1);

    // reset in the middle of a refill
    rc = resp_count;
    im_req_valid = 1'b1;
    im_req_addr  = 64'h8000_0808;
    step();
    im_req_valid = 1'b0;
    step();
    bm_req_ready = 1'b1;
    step();
    bm_req_ready = 1'b0;
    bm_resp_valid = 1'b1;
    bm_resp_rdata = 64'hc1;
    step();
    bm_resp_rdata = 64'hc2;
    step();
    rst = 1'b1;
    bm_resp_rdata = 64'hc3;
    step();
    chk("mid_rst_rvalid", {63'd0, im_resp_valid}, 64'd0);
    chk("mid_rst_rdata", im_resp_rdata, 64'd0);
    chk("mid_rst_bm", {63'd0, bm_req_valid}, 64'd0);
    bm_resp_rdata = 64'hc4;
    step();
    rst = 1'b0;
    cnt = 0;
    while (cnt < 200) begin
      step();
      bm_resp_valid = 1'b0;
      cnt++;
      if (im_req_ready) break;
    end
    chk("rst_sweep_len", 64'(cnt), 64'd64);
    chk("rst_noresp", 64'(resp_count), 64'(rc));
    fetch_miss(64'h8000_0808, 64'hd1, 64'hd2,
               64'hd3, 64'hd4, 64'hd2, -1);
    im_req_valid = 1'b1;
    im_req_addr  = 64'h8000_0818;
    step();
    im_req_valid = 1'b0;
    chk("final_hit", im_resp_rdata, 64'hd4);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter SETS, default 64, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter LINE_BEATS, default 4, 64-bit beats per line (power of 2).
REQ-003 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port im_req_addr  input  64  fetch byte address, bits [2:0] ignored.
REQ-006 SHALL have port im_req_valid  input  1  fetch request present.
REQ-007 SHALL have port im_req_ready  output  1  request accepted when valid&&ready.
REQ-008 SHALL have port im_resp_rdata  output  64  aligned 64-bit word containing the addressed instruction.
REQ-009 SHALL have port im_resp_valid  output  1  one-cycle pulse per accepted request, no back-pressure.
REQ-010 SHALL have port inv_req  input  1  single-cycle pulse: invalidate all lines (fence.i).
REQ-011 SHALL have port bm_req_addr  output  64  line-aligned refill address to backing memory.
REQ-012 SHALL have port bm_req_valid  output  1  refill request.
REQ-013 SHALL have port bm_req_ready  input  1  backing memory accepts request.
REQ-014 SHALL have port bm_resp_rdata  input  64  refill beat, ascending address order.
REQ-015 SHALL have port bm_resp_valid  input  1  refill beat present, no back-pressure.

Function
REQ-016 SHALL split addresses: offset = log2(LINE_BEATS*8) bits, index = next log2(SETS) bits, tag = remaining upper bits; per line store valid bit, tag, LINE_BEATS data words.
REQ-017 SHALL implement states INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP.
REQ-018 INIT: clear one valid bit per cycle, index 0..SETS-1, im_req_ready=0; after index SETS-1 go to IDLE.
REQ-019 IDLE: im_req_ready=1; on accept capture address, start synchronous tag/data read, go to LOOKUP.
REQ-020 LOOKUP hit (valid && tag match): im_resp_valid=1 with stored word in that cycle (latency exactly 1 cycle from accept); im_req_ready=1 in the same cycle so back-to-back hits sustain one response per cycle (accept -> stay LOOKUP, else -> IDLE).
REQ-021 LOOKUP miss: im_req_ready=0, im_resp_valid=0, go to MISS_REQ next cycle.
REQ-022 MISS_REQ: bm_req_valid=1, bm_req_addr = captured address with offset bits zeroed, held stable until bm_req_ready; on handshake go to MISS_WAIT with beat counter 0.
REQ-023 MISS_WAIT: each bm_resp_valid writes beat to data[index][counter], counter increments; beat with counter == captured word offset is latched as response word; bm_resp_valid in any other state SHALL be ignored.
REQ-024 On beat LINE_BEATS-1: write tag, set valid, go to RESP.
REQ-025 RESP: im_resp_valid=1 with latched word, im_req_ready=0, next state IDLE.
REQ-026 SHALL allow exactly one outstanding fetch; im_req_ready=0 in MISS_REQ, MISS_WAIT, RESP, INIT.
REQ-027 inv_req SHALL set a pending flag in any state; flag is serviced when state is IDLE, or LOOKUP with no new accept, by entering INIT (flag cleared); an in-flight miss SHALL complete and respond first, its line then cleared by the sweep.
REQ-028 inv_req coincident with IDLE SHALL suppress accept that cycle (im_req_ready=0) and enter INIT next cycle.

Reset
REQ-029 rst SHALL force state INIT with sweep index 0, clear inv pending flag and beat counter, and hold im_req_ready=0, im_resp_valid=0, bm_req_valid=0, im_resp_rdata=0 through reset.
REQ-030 rst during MISS_REQ/MISS_WAIT SHALL abandon the refill with no response; leftover backing beats during INIT/IDLE are ignored.
REQ-031 Data and tag arrays need not be reset; only valid bits are cleared by the INIT sweep (SETS cycles).

Verification
REQ-032 Reset, then count cycles -> im_req_ready first 1 exactly 64 cycles after rst deasserts; no responses during sweep.
REQ-033 Cold fetch 0x80000004 -> bm_req_addr=0x80000000; beats 0x11,0x22,0x33,0x44 -> im_resp_valid once with 0x11 in RESP; refetch 0x80000004 -> 0x11 one cycle after accept.
REQ-034 Warm line 0x80000000, fetch 0x80000000,0x80000008,0x80000010,0x80000018 back-to-back -> four consecutive im_resp_valid cycles returning beats in order, bm_req_valid never asserted.
REQ-035 Conflict: fill 0x80000000 then fetch 0x80000800 (same index, tag differs) -> miss, refill; then 0x80000000 misses again.
REQ-036 inv_req pulse during MISS_WAIT for 0x80000000 -> refill response delivered, then 64-cycle sweep; next fetch 0x80000000 misses.
REQ-037 rst asserted mid-refill after 2 beats -> no im_resp_valid, remaining beats ignored, fetch of same address after sweep misses.
